// File: rtl/if_pkg.sv
// Shared constants and the prefetch entry type for the LEGv8 instruction-fetch slice.
// Imported by the interface, the prefetch queue and the fetch unit top.
package if_pkg;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 32;

    localparam logic [ADDR_W-1:0] RESET_PC  = 16'h0000;
    localparam logic [DATA_W-1:0] HALT_WORD = 32'hD600_03E0;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [DATA_W-1:0] instr;
    } fetch_entry_t;

    function automatic logic is_halt(input logic [DATA_W-1:0] word,
                                     input logic [DATA_W-1:0] halt_word);
        return word == halt_word;
    endfunction

    // Word-address increment; wraps naturally at 2^ADDR_W.
    function automatic logic [ADDR_W-1:0] pc_inc(input logic [ADDR_W-1:0] pc);
        return pc + ADDR_W'(1);
    endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Fetch-side bus bundle: instruction ROM address/data plus the decode valid/ready handshake.
// master = fetch unit, slave = ROM + decode environment.
interface instr_fetch_unit_if;
    import if_pkg::*;

    logic [ADDR_W-1:0] imem_addr;
    logic [DATA_W-1:0] imem_data;
    logic              if_valid;
    logic [DATA_W-1:0] if_instr;
    logic [ADDR_W-1:0] if_pc;
    logic              if_ready;

    modport master (
        output imem_addr,
        input  imem_data,
        output if_valid,
        output if_instr,
        output if_pc,
        input  if_ready
    );

    modport slave (
        input  imem_addr,
        output imem_data,
        input  if_valid,
        input  if_instr,
        input  if_pc,
        output if_ready
    );

endinterface

// File: rtl/fetch_queue.sv
// Small synchronous FIFO of fetched {pc, instr} entries with a combinational head.
// Flush wins over push and pop; push into a full queue is accepted only alongside a pop.
module fetch_queue
    import if_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic         flush_i,
    input  fetch_entry_t entry_i,
    output logic         full_o,
    output logic         empty_o,
    output fetch_entry_t head_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    fetch_entry_t     mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign head_o  = mem_q[rd_ptr_q];

    assign do_pop  = pop_i & ~empty_o & ~flush_i;
    assign do_push = push_i & (~full_o | do_pop) & ~flush_i;

    // DEPTH is a power of two, so the pointers wrap without an explicit compare.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            if (do_push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (do_push) begin
            mem_q[wr_ptr_q] <= entry_i;
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// LEGv8 instruction-fetch initiator: owns the PC, feeds the prefetch queue from the
// combinational ROM, handles redirect/flush and stops after fetching the BR XZR halt word.
module instr_fetch_unit
    import if_pkg::*;
#(
    parameter int                DEPTH     = 2,
    parameter logic [ADDR_W-1:0] RESET_PC  = if_pkg::RESET_PC,
    parameter logic [DATA_W-1:0] HALT_WORD = if_pkg::HALT_WORD
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     fetch_en,
    input  logic                     redirect_valid,
    input  logic [ADDR_W-1:0]        redirect_pc,
    output logic                     halted,
    instr_fetch_unit_if.master       bus
);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              halted_q, halted_d;
    logic              q_full;
    logic              q_empty;
    logic              pop;
    logic              push;
    logic              fetched_halt;
    fetch_entry_t      head;
    fetch_entry_t      new_entry;

    assign pop          = ~q_empty & bus.if_ready;
    assign push         = fetch_en & ~halted_q & ~redirect_valid & (~q_full | pop);
    assign fetched_halt = is_halt(bus.imem_data, HALT_WORD);

    assign new_entry.pc    = pc_q;
    assign new_entry.instr = bus.imem_data;

    // Redirect doubles as the queue flush; the queue itself suppresses the pop.
    fetch_queue #(
        .DEPTH (DEPTH)
    ) u_queue (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (redirect_valid),
        .entry_i (new_entry),
        .full_o  (q_full),
        .empty_o (q_empty),
        .head_o  (head)
    );

    always_comb begin
        pc_d     = pc_q;
        halted_d = halted_q;
        if (redirect_valid) begin
            pc_d     = redirect_pc;
            halted_d = 1'b0;
        end else if (push) begin
            if (fetched_halt) begin
                halted_d = 1'b1;
            end else begin
                pc_d = pc_inc(pc_q);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q     <= RESET_PC;
            halted_q <= 1'b0;
        end else begin
            pc_q     <= pc_d;
            halted_q <= halted_d;
        end
    end

    assign bus.imem_addr = pc_q;
    assign bus.if_valid  = ~q_empty;
    assign bus.if_instr  = q_empty ? '0 : head.instr;
    assign bus.if_pc     = q_empty ? '0 : head.pc;
    assign halted        = halted_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed table, hand-written corner sequences,
// and randomized traffic compared against a queue-based behavioural model.
module tb_instr_fetch_unit;
    import if_pkg::*;

    localparam int DEPTH = 2;

    logic              clk;
    logic              rst_n;
    logic              fetch_en;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;
    logic              halted;

    instr_fetch_unit_if bus ();

    instr_fetch_unit #(
        .DEPTH     (DEPTH),
        .RESET_PC  (16'h0000),
        .HALT_WORD (32'hD600_03E0)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .fetch_en       (fetch_en),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halted         (halted),
        .bus            (bus)
    );

    logic [DATA_W-1:0] rom [0:65535];
    assign bus.imem_data = rom[bus.imem_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Behavioural model state
    fetch_entry_t      mq[$];
    logic [ADDR_W-1:0] m_pc;
    bit                m_halted;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic cmp_model();
        fetch_entry_t h;
        h = (mq.size() > 0) ? mq[0] : '0;
        chk("model.if_valid", {31'd0, bus.if_valid}, {31'd0, mq.size() > 0});
        chk("model.if_pc", {16'd0, bus.if_pc}, {16'd0, h.pc});
        chk("model.if_instr", bus.if_instr, h.instr);
        chk("model.imem_addr", {16'd0, bus.imem_addr}, {16'd0, m_pc});
        chk("model.halted", {31'd0, halted}, {31'd0, m_halted});
    endtask

    // Drive one cycle of inputs, advance model and DUT by one edge, compare at the falling edge.
    task automatic step(input logic fen, input logic rv, input logic [15:0] rpc, input logic rdy);
        bit                m_pop;
        bit                m_push;
        logic [DATA_W-1:0] w;
        fetch_entry_t      e;
        fetch_en       = fen;
        redirect_valid = rv;
        redirect_pc    = rpc;
        bus.if_ready   = rdy;
        m_pop  = (mq.size() > 0) && rdy;
        w      = rom[m_pc];
        m_push = fen && !m_halted && (mq.size() < DEPTH || m_pop);
        @(posedge clk);
        if (rv) begin
            mq.delete();
            m_pc     = rpc;
            m_halted = 0;
        end else begin
            if (m_pop) void'(mq.pop_front());
            if (m_push) begin
                e.pc    = m_pc;
                e.instr = w;
                mq.push_back(e);
                if (w == 32'hD600_03E0) m_halted = 1;
                else m_pc = m_pc + 16'd1;
            end
        end
        @(negedge clk);
        cmp_model();
    endtask

    task automatic do_reset();
        fetch_en       = 0;
        redirect_valid = 0;
        redirect_pc    = '0;
        bus.if_ready   = 0;
        rst_n          = 0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1;
        mq.delete();
        m_pc     = 16'h0000;
        m_halted = 0;
        chk("reset.if_valid", {31'd0, bus.if_valid}, 32'd0);
        chk("reset.if_instr", bus.if_instr, 32'd0);
        chk("reset.if_pc", {16'd0, bus.if_pc}, 32'd0);
        chk("reset.imem_addr", {16'd0, bus.imem_addr}, 32'd0);
        chk("reset.halted", {31'd0, halted}, 32'd0);
    endtask

    typedef struct {
        logic        fen;
        logic        rv;
        logic [15:0] rpc;
        logic        rdy;
        logic        exp_valid;
        logic [15:0] exp_pc;
        logic [31:0] exp_instr;
        logic [15:0] exp_addr;
        logic        exp_halted;
    } vec_t;

    vec_t tbl[7];
    logic [15:0] got[$];

    initial begin
        for (int a = 0; a < 65536; a++) begin
            logic [31:0] w;
            w = $urandom;
            if (w == 32'hD600_03E0) w = w ^ 32'h1;
            if (a >= 8 && a < 16'hFFF0 && (a % 23) == 0) w = 32'hD600_03E0;
            rom[a] = w;
        end
        rom[0] = 32'hF840_0081;
        rom[1] = 32'h8B00_0022;
        rom[2] = 32'h8B01_0043;
        rom[3] = 32'hF800_0083;
        rom[4] = 32'hD600_03E0;

        // Straight-line program run ending on the halt word
        tbl[0] = '{1, 0, 16'h0, 1, 1, 16'h0, 32'hF840_0081, 16'h1, 0};
        tbl[1] = '{1, 0, 16'h0, 1, 1, 16'h1, 32'h8B00_0022, 16'h2, 0};
        tbl[2] = '{1, 0, 16'h0, 1, 1, 16'h2, 32'h8B01_0043, 16'h3, 0};
        tbl[3] = '{1, 0, 16'h0, 1, 1, 16'h3, 32'hF800_0083, 16'h4, 0};
        tbl[4] = '{1, 0, 16'h0, 1, 1, 16'h4, 32'hD600_03E0, 16'h4, 1};
        tbl[5] = '{1, 0, 16'h0, 1, 0, 16'h0, 32'h0,         16'h4, 1};
        tbl[6] = '{1, 0, 16'h0, 1, 0, 16'h0, 32'h0,         16'h4, 1};

        do_reset();
        for (int i = 0; i < 7; i++) begin
            step(tbl[i].fen, tbl[i].rv, tbl[i].rpc, tbl[i].rdy);
            chk("tbl.if_valid", {31'd0, bus.if_valid}, {31'd0, tbl[i].exp_valid});
            chk("tbl.if_pc", {16'd0, bus.if_pc}, {16'd0, tbl[i].exp_pc});
            chk("tbl.if_instr", bus.if_instr, tbl[i].exp_instr);
            chk("tbl.imem_addr", {16'd0, bus.imem_addr}, {16'd0, tbl[i].exp_addr});
            chk("tbl.halted", {31'd0, halted}, {31'd0, tbl[i].exp_halted});
            $display("vec %0d: valid=%0b pc=%h instr=%h addr=%h halted=%0b",
                     i, bus.if_valid, bus.if_pc, bus.if_instr, bus.imem_addr, halted);
        end

        // Backpressure from reset: queue fills, PC stalls, then drains in order
        do_reset();
        for (int i = 0; i < 4; i++) step(1, 0, 16'h0, 0);
        chk("bp.imem_addr", {16'd0, bus.imem_addr}, 32'h2);
        chk("bp.if_pc", {16'd0, bus.if_pc}, 32'h0);
        got.delete();
        for (int i = 0; i < 20; i++) begin
            if (bus.if_valid) got.push_back(bus.if_pc);
            step(1, 0, 16'h0, 1);
        end
        chk("bp.count", got.size(), 32'd5);
        for (int i = 0; i < got.size() && i < 5; i++) chk("bp.order", {16'd0, got[i]}, i);
        $display("backpressure: %0d entries delivered", got.size());

        // Redirect with a full queue; the popped head 0 and entry 1 must vanish
        do_reset();
        for (int i = 0; i < 3; i++) step(1, 0, 16'h0, 0);
        step(1, 1, 16'h0002, 1);
        chk("redir.if_valid", {31'd0, bus.if_valid}, 32'd0);
        step(1, 0, 16'h0, 1);
        chk("redir.if_pc", {16'd0, bus.if_pc}, 32'h2);
        chk("redir.if_instr", bus.if_instr, 32'h8B01_0043);
        got.delete();
        for (int i = 0; i < 10; i++) begin
            step(1, 0, 16'h0, 1);
            if (bus.if_valid) got.push_back(bus.if_pc);
        end
        chk("redir.tail_count", got.size(), 32'd2);
        for (int i = 0; i < got.size() && i < 2; i++) chk("redir.tail", {16'd0, got[i]}, 3 + i);
        $display("redirect-full: tail of %0d entries after target", got.size());

        // Redirect while halted restarts fetch from 0
        chk("halt.before", {31'd0, halted}, 32'd1);
        step(1, 1, 16'h0000, 1);
        chk("halt.cleared", {31'd0, halted}, 32'd0);
        chk("halt.gap_valid", {31'd0, bus.if_valid}, 32'd0);
        step(1, 0, 16'h0, 1);
        chk("halt.restart_pc", {16'd0, bus.if_pc}, 32'h0);
        chk("halt.restart_instr", bus.if_instr, 32'hF840_0081);
        $display("redirect-halted: pc=%h instr=%h", bus.if_pc, bus.if_instr);

        // PC wrap-around at the top of the address space
        step(1, 1, 16'hFFFF, 1);
        step(1, 0, 16'h0, 1);
        chk("wrap.pc0", {16'd0, bus.if_pc}, 32'hFFFF);
        step(1, 0, 16'h0, 1);
        chk("wrap.pc1", {16'd0, bus.if_pc}, 32'h0000);
        step(1, 0, 16'h0, 1);
        chk("wrap.pc2", {16'd0, bus.if_pc}, 32'h0001);
        $display("wrap: last pc=%h", bus.if_pc);

        // Asynchronous reset between edges with two entries queued
        do_reset();
        for (int i = 0; i < 3; i++) step(1, 0, 16'h0, 0);
        chk("arst.pre_valid", {31'd0, bus.if_valid}, 32'd1);
        #2;
        fetch_en = 0;
        rst_n    = 0;
        #1;
        chk("arst.if_valid", {31'd0, bus.if_valid}, 32'd0);
        chk("arst.halted", {31'd0, halted}, 32'd0);
        chk("arst.imem_addr", {16'd0, bus.imem_addr}, 32'h0);
        chk("arst.if_instr", bus.if_instr, 32'h0);
        #1;
        rst_n = 1;
        mq.delete();
        m_pc     = 16'h0000;
        m_halted = 0;
        @(negedge clk);
        cmp_model();
        step(1, 0, 16'h0, 1);
        chk("arst.resume0", {16'd0, bus.if_pc}, 32'h0);
        step(1, 0, 16'h0, 1);
        chk("arst.resume1", {16'd0, bus.if_pc}, 32'h1);
        $display("async-reset: resumed at pc=%h", bus.if_pc);

        // Randomized traffic against the model
        do_reset();
        for (int i = 0; i < 2000; i++) begin
            logic        fen;
            logic        rv;
            logic        rdy;
            logic [15:0] rpc;
            fen = ($urandom_range(0, 9) < 8);
            rdy = ($urandom_range(0, 9) < 7);
            rv  = ($urandom_range(0, 99) < 4);
            rpc = ($urandom_range(0, 4) == 0) ? 16'($urandom_range(16'hFFF8, 16'hFFFF))
                                              : 16'($urandom_range(0, 40));
            step(fen, rv, rpc, rdy);
        end
        $display("random: 2000 cycles done");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Instruction-fetch initiator for the pipelined LEGv8 core; drives the word address into the combinational instruction ROM and captures the returned word.
Maintains the PC and buffers fetched words in a small prefetch queue, then presents them to decode over a valid/ready handshake.
Handles branch redirects, with flush, and halts on the BR XZR halt word.

Parameters:
ADDR_W, 16, instruction word-address width (PC increments by 1 per instruction)
DATA_W, 32, instruction width
DEPTH, 2, prefetch queue entries (power of two, >=2)
RESET_PC, 16'h0000, PC value after reset
HALT_WORD, 32'hD60003E0, encoding of BR XZR; fetch stops after it

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
fetch_en  in  1  global fetch enable
imem_addr  out  ADDR_W  ROM address; always equals the PC register
imem_data  in  DATA_W  ROM word for imem_addr, valid in the same cycle
redirect_valid  in  1  branch/jump redirect request
redirect_pc  in  ADDR_W  redirect target word address
if_valid  out  1  queue head valid to decode
if_instr  out  DATA_W  head instruction; 0 when if_valid=0
if_pc  out  ADDR_W  head PC; 0 when if_valid=0
if_ready  in  1  decode accepts head this cycle
halted  out  1  halt word fetched; no further fetch

Behaviour:
- Reset (async, rst_n=0): pc=RESET_PC, queue empty, if_valid=0, if_instr=0, if_pc=0, halted=0. Reset takes effect immediately, without waiting for a clock edge.
- pop = if_valid & if_ready. Head advances at the clock edge.
- push = fetch_en & ~halted & ~redirect_valid & (count<DEPTH | pop). When full, push and pop in the same cycle are allowed; count is unchanged.
- On push:
  - Enqueue {pc, imem_data}.
  - If imem_data==HALT_WORD: halted<=1 and pc holds.
  - Else pc<=pc+1, modulo 2^ADDR_W (0xFFFF wraps to 0x0000).
- No push: pc holds, so imem_addr is stable.
- Latency: a word fetched in cycle N appears at if_* in cycle N+1 when the queue was empty. Throughput is 1 instr/cycle with if_ready=1.
- Redirect (highest priority):
  - At the edge: queue flushed (count=0), pc<=redirect_pc, halted<=0.
  - No push and no pop are recorded that cycle; a head being popped the same cycle is discarded.
  - if_valid=0 in the following cycle. The redirect-target word appears at if_* one cycle after that.
- The halt word itself is delivered to decode like any instruction. halted stays 1 until a redirect or reset.
- fetch_en=0: no push; pops continue normally.
- Queue is FIFO-ordered: no drop or duplication under any if_ready pattern.
- Outputs if_instr/if_pc are masked to 0 combinationally when empty.

Decomposition:
- Package if_pkg holds:
  - ADDR_W, DATA_W, HALT_WORD, RESET_PC constants
  - typedef fetch_entry_t {pc, instr}
- One sub-module, fetch_queue: synchronous FIFO of fetch_entry_t.
  - Ports: push, pop, flush, full, empty, head.
  - Asynchronous active-low reset.
  - Flush has priority over push and pop.
- The top module holds the PC, halt and push/redirect control.

Test Plan:
- Reset, then fetch_en=1, if_ready=1, ROM program at 0..3:
  - if_* yields, in order, (0,F8400081), (1,8B000022), (2,8B010043), (3,F8000083), (4,D60003E0).
  - halted=1 the cycle after addr 4 is fetched; imem_addr stays 0x0004 and no further if_valid.
- Backpressure, if_ready=0 from start:
  - After 2 pushes the queue is full; imem_addr holds 0x0002 and if_pc stays 0.
  - Raise if_ready: the sequence 0,1,2,3,4 is delivered exactly once.
- Redirect with full queue, redirect_pc=0x0002 pulsed 1 cycle:
  - Next cycle if_valid=0.
  - The following cycle if_pc=2, if_instr=8B010043; the old entries 0/1 are never seen.
- Redirect while halted, redirect_pc=0x0000:
  - halted drops to 0 at the edge and fetch restarts.
  - (0,F8400081) is delivered 2 cycles after the redirect.
- Wrap-around with a bench memory model (non-halt words):
  - Redirect to 0xFFFF; if_pc sequence is FFFF then 0000 then 0001.
- Async reset mid-stream, rst_n low between clock edges with queue holding 2 entries:
  - if_valid=0, halted=0, imem_addr=0x0000 before the next edge.
  - After release, fetch resumes from 0x0000.
